gpu_regfile: RTL

- Parametrised successor to the per-context register bank.
- Holds NUM_CTX contexts × REGS registers of DATA_W bits, with 1 byte-masked write port and 2 independent registered read ports.
- A sequencer zero-fills the whole array after reset and can clear one context on request.
- Sits between the warp scheduler/operand collector and the ALU writeback path.

---
 rtl/gpu_pkg.sv | 23 ++
 rtl/gpu_regfile_mem.sv | 82 ++++++++
 rtl/gpu_regfile.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
`default_nettype none
// ============================================================================
//  gpu_pkg
//  Shared defaults and sequencer state encoding for the GPU register bank.
//  Revision: 1.0
// ============================================================================
package gpu_pkg;

    localparam int GPU_DATA_W  = 64;
    localparam int GPU_REGS    = 32;
    localparam int GPU_NUM_CTX = 8;
    localparam int GPU_CTX_W   = $clog2(GPU_NUM_CTX);
    localparam int GPU_REG_W   = $clog2(GPU_REGS);
    localparam int GPU_ADDR_W  = GPU_CTX_W + GPU_REG_W;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

endpackage : gpu_pkg
`default_nettype wire

// File: rtl/gpu_regfile_mem.sv
`default_nettype none
// ============================================================================
//  gpu_regfile_mem
//  DEPTH x DATA_W storage: one byte-masked write port, two registered read
//  ports with per-byte write-first bypass.
//  Revision: 1.0
// ============================================================================
module gpu_regfile_mem
    import gpu_pkg::*;
#(
    parameter int DATA_W = GPU_DATA_W,
    parameter int ADDR_W = GPU_ADDR_W,
    parameter int DEPTH  = 2 ** ADDR_W,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [BE_W-1:0]   wr_be_i,
    input  logic              rd0_en_i,
    input  logic [ADDR_W-1:0] rd0_addr_i,
    input  logic              rd1_en_i,
    input  logic [ADDR_W-1:0] rd1_addr_i,
    output logic [DATA_W-1:0] rd0_data_o,
    output logic [DATA_W-1:0] rd1_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd0_data_q;
    logic [DATA_W-1:0] rd1_data_q;
    logic [DATA_W-1:0] w_rd0_merged;
    logic [DATA_W-1:0] w_rd1_merged;

    // Bytes being written this cycle replace the stored bytes on a hit.
    function automatic logic [DATA_W-1:0] f_bypass(input logic [DATA_W-1:0] stored,
                                                   input logic              hit);
        logic [DATA_W-1:0] merged;
        merged = stored;
        for (int b = 0; b < BE_W; b++) begin
            if (hit && wr_be_i[b]) begin
                merged[8*b +: 8] = wr_data_i[8*b +: 8];
            end
        end
        return merged;
    endfunction

    always_comb begin
        w_rd0_merged = f_bypass(mem_q[rd0_addr_i], wr_en_i && (wr_addr_i == rd0_addr_i));
        w_rd1_merged = f_bypass(mem_q[rd1_addr_i], wr_en_i && (wr_addr_i == rd1_addr_i));
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int b = 0; b < BE_W; b++) begin
                if (wr_be_i[b]) begin
                    mem_q[wr_addr_i][8*b +: 8] <= wr_data_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd0_data_q <= '0;
            rd1_data_q <= '0;
        end else begin
            if (rd0_en_i) begin
                rd0_data_q <= w_rd0_merged;
            end
            if (rd1_en_i) begin
                rd1_data_q <= w_rd1_merged;
            end
        end
    end

    assign rd0_data_o = rd0_data_q;
    assign rd1_data_o = rd1_data_q;

endmodule : gpu_regfile_mem
`default_nettype wire

// File: rtl/gpu_regfile.sv
`default_nettype none
// ============================================================================
//  gpu_regfile
//  Multi-context register bank with a zero-fill / context-clear sequencer
//  in front of gpu_regfile_mem.
//  Revision: 1.0
// ============================================================================
module gpu_regfile
    import gpu_pkg::*;
#(
    parameter int DATA_W  = GPU_DATA_W,
    parameter int REGS    = GPU_REGS,
    parameter int NUM_CTX = GPU_NUM_CTX,
    parameter int CTX_W   = $clog2(NUM_CTX),
    parameter int REG_W   = $clog2(REGS)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ready,
    input  logic                wr_en,
    input  logic [CTX_W-1:0]    wr_ctx,
    input  logic [REG_W-1:0]    wr_reg,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                rd0_en,
    input  logic [CTX_W-1:0]    rd0_ctx,
    input  logic [REG_W-1:0]    rd0_reg,
    output logic [DATA_W-1:0]   rd0_data,
    output logic                rd0_valid,
    input  logic                rd1_en,
    input  logic [CTX_W-1:0]    rd1_ctx,
    input  logic [REG_W-1:0]    rd1_reg,
    output logic [DATA_W-1:0]   rd1_data,
    output logic                rd1_valid,
    input  logic                clr_req,
    input  logic [CTX_W-1:0]    clr_ctx
);

    localparam int ADDR_W = CTX_W + REG_W;
    localparam int DEPTH  = NUM_CTX * REGS;
    localparam int BE_W   = DATA_W / 8;

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [REG_W-1:0]  c_LAST_REG  = REG_W'(REGS - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [CTX_W-1:0]  clr_ctx_q;
    logic              ready_q;
    logic              rd0_valid_q;
    logic              rd1_valid_q;

    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_data;
    logic [BE_W-1:0]   w_mem_be;
    logic              w_rd0_acc;
    logic              w_rd1_acc;

    assign w_rd0_acc = ready_q && rd0_en;
    assign w_rd1_acc = ready_q && rd1_en;

    // The sweep owns the write port whenever the bank is not ready.
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_addr = '0;
        w_mem_data = '0;
        w_mem_be   = '0;
        case (state_q)
            ST_INIT: begin
                w_mem_we   = 1'b1;
                w_mem_addr = ptr_q;
                w_mem_be   = '1;
            end
            ST_CLEAR: begin
                w_mem_we   = 1'b1;
                w_mem_addr = {clr_ctx_q, ptr_q[REG_W-1:0]};
                w_mem_be   = '1;
            end
            default: begin
                w_mem_we   = ready_q && wr_en && (|wr_be);
                w_mem_addr = {wr_ctx, wr_reg};
                w_mem_data = wr_data;
                w_mem_be   = wr_be;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            ptr_q       <= '0;
            clr_ctx_q   <= '0;
            ready_q     <= 1'b0;
            rd0_valid_q <= 1'b0;
            rd1_valid_q <= 1'b0;
        end else begin
            rd0_valid_q <= w_rd0_acc;
            rd1_valid_q <= w_rd1_acc;
            case (state_q)
                ST_INIT: begin
                    if (ptr_q == c_LAST_ADDR) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                        ptr_q   <= '0;
                    end else begin
                        ptr_q <= ptr_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (clr_req) begin
                        state_q   <= ST_CLEAR;
                        ready_q   <= 1'b0;
                        clr_ctx_q <= clr_ctx;
                        ptr_q     <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (ptr_q[REG_W-1:0] == c_LAST_REG) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                        ptr_q   <= '0;
                    end else begin
                        ptr_q <= ptr_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                    ready_q <= 1'b0;
                    ptr_q   <= '0;
                end
            endcase
        end
    end

    gpu_regfile_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .BE_W   (BE_W)
    ) u_mem (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (w_mem_we),
        .wr_addr_i  (w_mem_addr),
        .wr_data_i  (w_mem_data),
        .wr_be_i    (w_mem_be),
        .rd0_en_i   (w_rd0_acc),
        .rd0_addr_i ({rd0_ctx, rd0_reg}),
        .rd1_en_i   (w_rd1_acc),
        .rd1_addr_i ({rd1_ctx, rd1_reg}),
        .rd0_data_o (rd0_data),
        .rd1_data_o (rd1_data)
    );

    assign ready     = ready_q;
    assign rd0_valid = rd0_valid_q;
    assign rd1_valid = rd1_valid_q;

endmodule : gpu_regfile
`default_nettype wire
